// File: rtl/native_mem_pkg.sv
// Shared types and constants for the PicoRV32 native-bus memory responder.
package native_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h1000_0000;

  localparam int CON_CNT_LSB  = 0;
  localparam int CON_CNT_MSB  = 7;
  localparam int CON_FULL_BIT = 8;

  function automatic logic [31:0] con_status(input logic full, input logic [7:0] count);
    logic [31:0] s;
    s                          = '0;
    s[CON_CNT_MSB:CON_CNT_LSB] = count;
    s[CON_FULL_BIT]            = full;
    return s;
  endfunction

endpackage

// File: rtl/native_mem_responder_if.sv
// Core-side memory port plus the exported console byte stream.
interface native_mem_responder_if;
  import native_mem_pkg::*;

  logic        mem_valid;
  logic        mem_instr;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        con_valid;
  logic        con_ready;
  logic [7:0]  con_data;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, con_ready,
    input  mem_ready, mem_rdata, con_valid, con_data
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb, con_ready,
    output mem_ready, mem_rdata, con_valid, con_data
  );

endinterface

// File: rtl/native_mem_responder_console_fifo.sv
// Console byte FIFO; dout is the head entry, push is accepted when full if a pop
// happens on the same edge, so it never overflows or underflows.
module console_fifo
  import native_mem_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/native_mem_responder.sv
// PicoRV32 native-bus responder: RAM, console port, out-of-range capture.
// mem_ready comes WAIT_CYCLES+1 cycles after a request is seen; a console push with a full FIFO stalls it.
module native_mem_responder
  import native_mem_pkg::*;
#(
  parameter int          MEM_WORDS     = 262144,
  parameter int          WAIT_CYCLES   = 0,
  parameter logic [31:0] CONSOLE_ADDR  = CONSOLE_ADDR_DEF,
  parameter int          CONSOLE_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  native_mem_responder_if.slave  bus,
  output logic                   oor_err,
  output logic [31:0]            oor_addr
);

  localparam int AW    = $clog2(MEM_WORDS);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int FCW   = $clog2(CONSOLE_DEPTH) + 1;

  logic [31:0] memory [MEM_WORDS];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]       wstrb_q, wstrb_d;
  logic             ready_q, ready_d, ram_sel_q, ram_sel_d;
  logic             oor_err_q, oor_err_d;
  logic [31:0]      oor_addr_q, oor_addr_d;
  logic [31:0]      ram_rdata_q;

  logic [31:0]      a_addr, a_wdata;
  logic [3:0]       a_wstrb;
  logic [AW-1:0]    ram_idx;
  logic             ram_hit, con_hit, is_wr, need_push, blocked, go_resp;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [7:0]       fifo_dout;
  logic             unused_instr;

  assign unused_instr = bus.mem_instr;

  // In IDLE the request is decoded straight off the bus so WAIT_CYCLES=0 can respond next cycle.
  assign a_addr  = (state_q == IDLE) ? bus.mem_addr  : addr_q;
  assign a_wdata = (state_q == IDLE) ? bus.mem_wdata : wdata_q;
  assign a_wstrb = (state_q == IDLE) ? bus.mem_wstrb : wstrb_q;

  assign ram_idx   = a_addr[AW+1:2];
  assign ram_hit   = {2'b00, a_addr[31:2]} < 32'(MEM_WORDS);
  assign con_hit   = !ram_hit && (a_addr[31:2] == CONSOLE_ADDR[31:2]);
  assign is_wr     = |a_wstrb;
  assign need_push = con_hit && is_wr && a_wstrb[0];
  assign fifo_pop  = !fifo_empty && bus.con_ready;
  assign blocked   = need_push && fifo_full && !fifo_pop;
  assign fifo_push = go_resp && need_push;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    ready_d    = 1'b0;
    rdata_d    = '0;
    ram_sel_d  = 1'b0;
    oor_err_d  = oor_err_q;
    oor_addr_d = oor_addr_q;
    go_resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.mem_valid) begin
          addr_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          wstrb_d = bus.mem_wstrb;
          if (WAIT_CYCLES == 0 && !blocked) begin
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = '0;
          go_resp = !blocked;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (go_resp) begin
      state_d   = RESP;
      ready_d   = 1'b1;
      ram_sel_d = ram_hit && !is_wr;
      if (con_hit && !is_wr) rdata_d = con_status(fifo_full, 8'(fifo_count));
      if (!ram_hit && !con_hit) begin
        oor_err_d = 1'b1;
        if (!oor_err_q) oor_addr_d = a_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      ram_sel_q  <= 1'b0;
      oor_err_q  <= 1'b0;
      oor_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      ram_sel_q  <= ram_sel_d;
      oor_err_q  <= oor_err_d;
      oor_addr_q <= oor_addr_d;
    end
  end

  // Contents survive reset; ram_rdata_q is only exposed through ram_sel_q.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (go_resp && ram_hit && a_wstrb[i]) memory[ram_idx][8*i +: 8] <= a_wdata[8*i +: 8];
    end
    ram_rdata_q <= memory[ram_idx];
  end

  console_fifo #(.DEPTH(CONSOLE_DEPTH), .WIDTH(8)) u_con_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (a_wdata[7:0]),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = ram_sel_q ? ram_rdata_q : rdata_q;
  assign bus.con_valid = !fifo_empty;
  assign bus.con_data  = fifo_dout;
  assign oor_err       = oor_err_q;
  assign oor_addr      = oor_addr_q;

endmodule

// File: tb/tb_native_mem_responder.sv
// Bench: dut0 with WAIT_CYCLES=0 and dut1 with WAIT_CYCLES=3 share one stimulus driver.
module tb_native_mem_responder;
  import native_mem_pkg::*;

  localparam int          MEMW = 262144;
  localparam logic [31:0] CON  = 32'h1000_0000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic        m_sel = 1'b0, m_valid = 1'b0, c_ready = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic [3:0]  m_wstrb = '0;
  logic        oor_err0, oor_err1, r_ready;
  logic [31:0] oor_addr0, oor_addr1, r_rdata;

  native_mem_responder_if if0 ();
  native_mem_responder_if if1 ();

  assign if0.mem_valid = m_valid && !m_sel;
  assign if1.mem_valid = m_valid && m_sel;
  assign if0.mem_instr = 1'b0;
  assign if1.mem_instr = 1'b1;
  assign if0.mem_addr  = m_addr;
  assign if1.mem_addr  = m_addr;
  assign if0.mem_wdata = m_wdata;
  assign if1.mem_wdata = m_wdata;
  assign if0.mem_wstrb = m_wstrb;
  assign if1.mem_wstrb = m_wstrb;
  assign if0.con_ready = c_ready;
  assign if1.con_ready = 1'b1;
  assign r_ready = m_sel ? if1.mem_ready : if0.mem_ready;
  assign r_rdata = m_sel ? if1.mem_rdata : if0.mem_rdata;

  native_mem_responder #(.MEM_WORDS(MEMW), .WAIT_CYCLES(0), .CONSOLE_ADDR(CON), .CONSOLE_DEPTH(8)) dut0 (
    .clk(clk), .resetn(resetn), .bus(if0), .oor_err(oor_err0), .oor_addr(oor_addr0));
  native_mem_responder #(.MEM_WORDS(MEMW), .WAIT_CYCLES(3), .CONSOLE_ADDR(CON), .CONSOLE_DEPTH(8)) dut1 (
    .clk(clk), .resetn(resetn), .bus(if1), .oor_err(oor_err1), .oor_addr(oor_addr1));

  int checks = 0, errors = 0, cyc = 0, last_rdy_cyc = 0, drained = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural reference: sparse word store, console byte queue, first-OOR record.
  logic [31:0] ram_m [logic [31:0]];
  logic [7:0]  con_q [$];
  bit   [1:0]  oor_seen = '0;
  logic [31:0] oor_first [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic model(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] exp, output bit known);
    logic [31:0] k, cur;
    k = {1'b0, sel, addr[31:2]};
    exp = '0;
    known = 1'b1;
    if (addr < 32'(MEMW * 4)) begin
      if (strb != 4'h0) begin
        cur = ram_m.exists(k) ? ram_m[k] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
        ram_m[k] = cur;
      end else if (ram_m.exists(k)) exp = ram_m[k];
      else known = 1'b0;
    end else if (addr[31:2] == CON[31:2]) begin
      if (strb != 4'h0) begin
        if (strb[0]) con_q.push_back(wdata[7:0]);
      end else begin
        exp = {23'b0, con_q.size() == 8, 8'(con_q.size())};
      end
    end else if (!oor_seen[sel]) begin
      oor_seen[sel]  = 1'b1;
      oor_first[sel] = addr;
    end
  endtask

  task automatic txn(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, output logic [31:0] rdata, output int lat);
    bit done, leak;
    done = 1'b0; leak = 1'b0; lat = 0; rdata = '0;
    @(negedge clk);
    m_sel = sel; m_addr = addr; m_wdata = wdata; m_wstrb = strb; m_valid = 1'b1;
    while (!done && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (r_ready) begin done = 1'b1; rdata = r_rdata; last_rdy_cyc = cyc; end
      else if (r_rdata !== 32'h0) leak = 1'b1;
    end
    m_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL txn_timeout: addr %h got no mem_ready in %0d cycles, expected a response", addr, lat);
    end else begin
      @(posedge clk); #1;
      chk("ready_single_pulse", 32'(r_ready), 32'h0);
      chk("rdata_zero_after_resp", r_rdata, 32'h0);
    end
    chk("rdata_zero_while_waiting", 32'(leak), 32'h0);
  endtask

  task automatic op(input string nm, input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                    input logic [3:0] strb, input bit chk_lat);
    logic [31:0] exp, got;
    bit known;
    int lat;
    model(sel, addr, wdata, strb, exp, known);
    txn(sel, addr, wdata, strb, got, lat);
    if (strb == 4'h0 && known) chk({nm, "_rdata"}, got, exp);
    if (chk_lat) chk({nm, "_latency"}, 32'(lat), sel ? 32'd4 : 32'd1);
  endtask

  always @(posedge clk) begin
    if (!resetn) con_q.delete();
    else if (if0.con_valid && c_ready) begin
      if (con_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL con_unexpected: got byte %h, expected none", if0.con_data);
      end else begin
        chk("con_byte", {24'h0, if0.con_data}, {24'h0, con_q.pop_front()});
        drained++;
      end
    end
  end

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
    bit          rd;
  } vec_t;

  vec_t vt [16];

  initial begin
    logic [31:0] got, exp, addr;
    bit known, seen;
    int lat, n, r, prev;

    vt[0]  = '{0, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0,         0};
    vt[1]  = '{0, 32'h0000_0040, 32'h0,         4'h0, 32'hDEAD_BEEF, 1};
    vt[2]  = '{0, 32'h0000_0080, 32'hAABB_CCDD, 4'hF, 32'h0,         0};
    vt[3]  = '{0, 32'h0000_0080, 32'h1122_3344, 4'h5, 32'h0,         0};
    vt[4]  = '{0, 32'h0000_0080, 32'h0,         4'h0, 32'hAA22_CC44, 1};
    vt[5]  = '{1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'h0,         0};
    vt[6]  = '{1, 32'h0000_0100, 32'h0,         4'h0, 32'hCAFE_F00D, 1};
    vt[7]  = '{1, 32'h0000_0104, 32'h0,         4'hF, 32'h0,         0};
    vt[8]  = '{1, 32'h0000_0104, 32'hFFFF_FFFF, 4'h8, 32'h0,         0};
    vt[9]  = '{1, 32'h0000_0104, 32'h0,         4'h0, 32'hFF00_0000, 1};
    vt[10] = '{0, 32'h0020_0000, 32'h0,         4'h0, 32'h0,         1};
    vt[11] = '{0, 32'h0030_0000, 32'h1234_5678, 4'hF, 32'h0,         0};
    vt[12] = '{0, CON,           32'h0,         4'h0, 32'h0,         1};
    vt[13] = '{1, 32'h000F_FFFC, 32'h0BAD_F00D, 4'hF, 32'h0,         0};
    vt[14] = '{1, 32'h000F_FFFC, 32'h0,         4'h0, 32'h0BAD_F00D, 1};
    vt[15] = '{1, 32'h0010_0000, 32'h0,         4'h0, 32'h0,         1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready0", 32'(if0.mem_ready), 32'h0);
    chk("rst_ready1", 32'(if1.mem_ready), 32'h0);
    chk("rst_rdata0", if0.mem_rdata, 32'h0);
    chk("rst_con_valid", 32'(if0.con_valid), 32'h0);
    chk("rst_con_data", {24'h0, if0.con_data}, 32'h0);
    chk("rst_oor_err", {30'h0, oor_err1, oor_err0}, 32'h0);
    chk("rst_oor_addr", oor_addr0 | oor_addr1, 32'h0);
    @(negedge clk) resetn = 1'b1;

    foreach (vt[i]) begin
      model(vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].strb, exp, known);
      txn(vt[i].sel, vt[i].addr, vt[i].wdata, vt[i].strb, got, lat);
      if (vt[i].rd) chk($sformatf("vec%0d_rdata", i), got, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), vt[i].sel ? 32'd4 : 32'd1);
    end
    chk("oor_err0", 32'(oor_err0), 32'h1);
    chk("oor_addr0_first", oor_addr0, 32'h0020_0000);
    chk("oor_err1", 32'(oor_err1), 32'h1);
    chk("oor_addr1_first", oor_addr1, 32'h0010_0000);

    // Back-to-back on the 3-wait-state instance: one response every 5 cycles.
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      op("b2b", 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1);
      if (i > 0) chk("b2b_spacing", 32'(last_rdy_cyc - prev), 32'd5);
      prev = last_rdy_cyc;
    end

    // Console: fill with the consumer stalled, then release.
    c_ready = 1'b0;
    drained = 0;
    for (int i = 0; i < 8; i++) op("con_push", 1'b0, CON, 32'h41 + i, 4'h1, 1'b1);
    txn(1'b0, CON, 32'h0, 4'h0, got, lat);
    chk("con_status_full", got, 32'h0000_0108);
    model(1'b0, CON, 32'h49, 4'h1, exp, known);
    @(negedge clk);
    m_sel = 1'b0; m_addr = CON; m_wdata = 32'h49; m_wstrb = 4'h1; m_valid = 1'b1;
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (r_ready) seen = 1'b1; end
    chk("con_full_stall", 32'(seen), 32'h0);
    @(negedge clk) c_ready = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 20) begin @(posedge clk); #1; n++; if (r_ready) seen = 1'b1; end
    m_valid = 1'b0;
    chk("con_release_cycles", 32'(n), 32'd1);
    n = 0;
    while ((con_q.size() != 0 || if0.con_valid) && n < 50) begin @(posedge clk); #1; n++; end
    chk("con_drained", 32'(drained), 32'd9);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      c_ready = (con_q.size() >= 7) ? 1'b1 : 1'($urandom_range(0, 1));
      if (r < 2) begin
        addr = ($urandom_range(0, 1) != 0) ? 32'h0010_0000 + ($urandom_range(0, 1023) << 2)
                                          : ({$urandom} | 32'h8000_0000);
        op("rnd_oor", 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)), 1'b1);
      end else if (r == 2) begin
        op("rnd_con", 1'b0, CON, $urandom, 4'($urandom_range(1, 15)), 1'b0);
      end else begin
        addr = 32'h0000_1000 + ($urandom_range(0, 31) << 2);
        n = $urandom_range(0, 1);
        if (!ram_m.exists({1'b0, 1'(n), addr[31:2]}))
          op("rnd_wr", 1'(n), addr, $urandom, 4'hF, 1'b1);
        else if ($urandom_range(0, 1) != 0)
          op("rnd_wr", 1'(n), addr, $urandom, 4'($urandom_range(1, 15)), 1'b1);
        else
          op("rnd_rd", 1'(n), addr, 32'h0, 4'h0, 1'b1);
      end
    end
    c_ready = 1'b1;
    n = 0;
    while ((con_q.size() != 0 || if0.con_valid) && n < 50) begin @(posedge clk); #1; n++; end
    chk("rnd_con_empty", 32'(con_q.size()), 32'h0);
    chk("rnd_oor_addr0", oor_addr0, oor_first[0]);
    chk("rnd_oor_addr1", oor_addr1, oor_first[1]);

    // Reset in the middle of a waiting write.
    op("pre_rst_wr", 1'b1, 32'h0000_0100, 32'hA5A5_A5A5, 4'hF, 1'b1);
    @(negedge clk);
    m_sel = 1'b1; m_addr = 32'h0000_0100; m_wdata = 32'h5A5A_5A5A; m_wstrb = 4'hF; m_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b0;
    m_valid = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(if1.mem_ready), 32'h0);
    chk("mid_rst_rdata", if1.mem_rdata, 32'h0);
    chk("mid_rst_oor", {30'h0, oor_err1, oor_err0}, 32'h0);
    chk("mid_rst_oor_addr", oor_addr0 | oor_addr1, 32'h0);
    chk("mid_rst_con_valid", 32'(if0.con_valid), 32'h0);
    seen = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (if1.mem_ready) seen = 1'b1; end
    chk("mid_rst_no_ready", 32'(seen), 32'h0);
    @(negedge clk) resetn = 1'b1;
    oor_seen = '0;
    op("post_rst_rd1", 1'b1, 32'h0000_0100, 32'h0, 4'h0, 1'b1);
    op("post_rst_rd0", 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1);
    txn(1'b0, CON, 32'h0, 4'h0, got, lat);
    chk("post_rst_con_status", got, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
